// File: rtl/mem_dma_initiator.sv
// Word-by-word memory copy initiator on the vproc request/response bus.
// One read then one write per word; faults on bus error, timeout or misalignment.
module mem_dma_initiator #(
    parameter int MEM_W          = 32,
    parameter int LEN_W          = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [31:0]        src_addr,
    input  logic [31:0]        dst_addr,
    input  logic [LEN_W-1:0]   len_words,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [1:0]         err_code,
    output logic [31:0]        err_addr,
    output logic [LEN_W-1:0]   words_done,
    output logic               mem_req_o,
    output logic [31:0]        mem_addr_o,
    output logic               mem_we_o,
    output logic [MEM_W/8-1:0] mem_be_o,
    output logic [MEM_W-1:0]   mem_wdata_o,
    input  logic               mem_rvalid_i,
    input  logic               mem_err_i,
    input  logic [MEM_W-1:0]   mem_rdata_i
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] STEP = 32'(MEM_W / 8);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_REQ  = 3'd1;
    localparam logic [2:0] S_RD_WAIT = 3'd2;
    localparam logic [2:0] S_WR_REQ  = 3'd3;
    localparam logic [2:0] S_WR_WAIT = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;
    localparam logic [2:0] S_FAULT   = 3'd6;

    logic [2:0]       state;
    logic [2:0]       nxt;
    logic [31:0]      cur_src;
    logic [31:0]      cur_dst;
    logic [31:0]      src_nxt;
    logic [31:0]      dst_nxt;
    logic [LEN_W-1:0] remaining;
    logic [CNT_W-1:0] cnt;
    logic             misal;
    logic             accept;
    logic             in_wait;
    logic             timed_out;
    logic             wr_ok;

    always_comb begin
        misal     = (src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00);
        accept    = (state == S_IDLE) && start;
        in_wait   = (state == S_RD_WAIT) || (state == S_WR_WAIT);
        timed_out = in_wait && !mem_err_i && !mem_rvalid_i && (cnt == CNT_MAX);
        wr_ok     = (state == S_WR_WAIT) && mem_rvalid_i && !mem_err_i;

        nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (misal)
                        nxt = S_FAULT;
                    else if (len_words == '0)
                        nxt = S_DONE;
                    else
                        nxt = S_RD_REQ;
                end
            end
            S_RD_REQ:  nxt = S_RD_WAIT;
            S_RD_WAIT: begin
                if (mem_err_i || timed_out)
                    nxt = S_FAULT;
                else if (mem_rvalid_i)
                    nxt = S_WR_REQ;
            end
            S_WR_REQ:  nxt = S_WR_WAIT;
            S_WR_WAIT: begin
                if (mem_err_i || timed_out)
                    nxt = S_FAULT;
                else if (mem_rvalid_i)
                    nxt = (remaining == LEN_W'(1)) ? S_DONE : S_RD_REQ;
            end
            default:   nxt = S_IDLE;
        endcase

        src_nxt = cur_src;
        dst_nxt = cur_dst;
        if (accept && !misal && (len_words != '0)) begin
            src_nxt = src_addr;
            dst_nxt = dst_addr;
        end else if (wr_ok) begin
            src_nxt = cur_src + STEP;
            dst_nxt = cur_dst + STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            cur_src     <= '0;
            cur_dst     <= '0;
            remaining   <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            err_code    <= 2'd0;
            err_addr    <= '0;
            words_done  <= '0;
            mem_req_o   <= 1'b0;
            mem_addr_o  <= '0;
            mem_we_o    <= 1'b0;
            mem_be_o    <= '0;
            mem_wdata_o <= '0;
        end else begin
            state   <= nxt;
            cur_src <= src_nxt;
            cur_dst <= dst_nxt;
            cnt     <= (in_wait && nxt == state) ? cnt + 1'b1 : '0;

            busy  <= (nxt == S_RD_REQ) || (nxt == S_RD_WAIT) ||
                     (nxt == S_WR_REQ) || (nxt == S_WR_WAIT);
            done  <= (nxt == S_DONE);
            error <= (nxt == S_FAULT);

            // Bus outputs are driven only for the single REQ cycle.
            mem_req_o   <= (nxt == S_RD_REQ) || (nxt == S_WR_REQ);
            mem_we_o    <= (nxt == S_WR_REQ);
            mem_be_o    <= ((nxt == S_RD_REQ) || (nxt == S_WR_REQ)) ? '1 : '0;
            mem_addr_o  <= (nxt == S_RD_REQ) ? src_nxt :
                           (nxt == S_WR_REQ) ? dst_nxt : '0;
            mem_wdata_o <= (nxt == S_WR_REQ) ? mem_rdata_i : '0;

            if (accept) begin
                if (misal) begin
                    err_code <= 2'd3;
                    err_addr <= (src_addr[1:0] != 2'b00) ? src_addr : dst_addr;
                end else if (len_words != '0) begin
                    err_code   <= 2'd0;
                    err_addr   <= '0;
                    words_done <= '0;
                    remaining  <= len_words;
                end
            end

            if (in_wait && nxt == S_FAULT) begin
                err_code <= mem_err_i ? 2'd1 : 2'd2;
                err_addr <= (state == S_RD_WAIT) ? cur_src : cur_dst;
            end

            if (wr_ok) begin
                words_done <= words_done + 1'b1;
                remaining  <= remaining - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_dma_initiator.sv
// Directed bench for mem_dma_initiator with a behavioural bus responder.
// Each task drives one scenario and checks its own expected values.
module tb_mem_dma_initiator;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] src_addr = '0;
    logic [31:0] dst_addr = '0;
    logic [15:0] len_words = '0;
    logic        busy, done, error;
    logic [1:0]  err_code;
    logic [31:0] err_addr;
    logic [15:0] words_done;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_rvalid_i = 1'b0;
    logic        mem_err_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_dma_initiator #(
        .MEM_W(32), .LEN_W(16), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .len_words(len_words),
        .busy(busy), .done(done), .error(error),
        .err_code(err_code), .err_addr(err_addr), .words_done(words_done),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_err_i(mem_err_i),
        .mem_rdata_i(mem_rdata_i)
    );

    // responder controls
    bit resp_en = 1'b1;
    bit lat_rand = 1'b0;
    bit late_rv = 1'b0;
    int fix_lat = 1;
    int err_wr = -1;
    int rd_base = 0;
    int wr_base = 0;
    int rd_n = 0;
    int wr_n = 0;
    logic [31:0] rd_hist[$];

    initial begin
        bit pend, p_we, late_pend;
        int left;
        logic [31:0] d;
        pend = 0; p_we = 0; late_pend = 0; left = 0;
        forever begin
            @(posedge clk);
            #1;
            mem_rvalid_i = 1'b0;
            mem_err_i = 1'b0;
            mem_rdata_i = '0;
            if (late_pend) begin
                mem_rvalid_i = 1'b1;
                late_pend = 0;
            end
            if (pend) begin
                if (left <= 1) begin
                    pend = 0;
                    if (!p_we) begin
                        d = lat_rand ? $urandom : 32'hA0 + 32'(rd_n - rd_base);
                        rd_hist.push_back(d);
                        rd_n++;
                        mem_rdata_i = d;
                        mem_rvalid_i = 1'b1;
                    end else begin
                        if (err_wr >= 0 && (wr_n - wr_base) == err_wr) begin
                            mem_err_i = 1'b1;
                            late_pend = late_rv;
                        end else begin
                            mem_rvalid_i = 1'b1;
                        end
                        wr_n++;
                    end
                end else begin
                    left--;
                end
            end
            if (mem_req_o === 1'b1 && resp_en) begin
                pend = 1;
                p_we = mem_we_o;
                left = lat_rand ? int'($urandom_range(1, 7)) : fix_lat;
            end
        end
    end

    // bus monitor
    logic [31:0] log_addr[$];
    logic [31:0] log_wd[$];
    bit          log_we[$];
    int done_cnt = 0;
    int err_cnt = 0;
    int b2b = 0;
    int be_bad = 0;

    initial begin
        bit prev_req;
        prev_req = 0;
        forever begin
            @(negedge clk);
            if (mem_req_o === 1'b1) begin
                log_addr.push_back(mem_addr_o);
                log_wd.push_back(mem_wdata_o);
                log_we.push_back(mem_we_o);
                if (mem_be_o !== 4'hF) be_bad++;
                if (prev_req) b2b++;
            end
            prev_req = (mem_req_o === 1'b1);
            if (done === 1'b1) done_cnt++;
            if (error === 1'b1) err_cnt++;
        end
    end

    int lb, db, eb, bb, beb, rhb;

    task automatic mark();
        lb = log_addr.size();
        db = done_cnt;
        eb = err_cnt;
        bb = b2b;
        beb = be_bad;
        rhb = rd_hist.size();
        rd_base = rd_n;
        wr_base = wr_n;
    endtask

    task automatic do_start(input logic [31:0] s, input logic [31:0] d,
                            input logic [15:0] n, output int s0);
        @(posedge clk);
        #1;
        start = 1'b1;
        src_addr = s;
        dst_addr = d;
        len_words = n;
        s0 = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_end(input int budget, output bit to,
                            output int ec, output bit was_err);
        to = 1; ec = 0; was_err = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done === 1'b1 || error === 1'b1) begin
                to = 0;
                ec = cyc;
                was_err = error;
                break;
            end
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({busy, done, error, mem_req_o, mem_we_o} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b want 00000",
                     {busy, done, error, mem_req_o, mem_we_o});
        end
        total++;
        if (err_code !== 2'd0) begin
            bad++; $display("FAIL reset_err_code: got %0d want 0", err_code);
        end
        total++;
        if (err_addr !== 32'h0) begin
            bad++; $display("FAIL reset_err_addr: got %h want 0", err_addr);
        end
        total++;
        if (words_done !== 16'h0) begin
            bad++; $display("FAIL reset_words_done: got %0d want 0", words_done);
        end
        total++;
        if ({mem_addr_o, mem_wdata_o} !== 64'h0) begin
            bad++; $display("FAIL reset_bus: got %h %h want 0", mem_addr_o, mem_wdata_o);
        end
        total++;
        if (mem_be_o !== 4'h0) begin
            bad++; $display("FAIL reset_be: got %h want 0", mem_be_o);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_nominal();
        logic [31:0] ea[6];
        logic [31:0] ew[6];
        bit to, we;
        int s0, ec;
        ea = '{32'h2000, 32'h1000, 32'h2004, 32'h1004, 32'h2008, 32'h1008};
        ew = '{32'h0, 32'hA0, 32'h0, 32'hA1, 32'h0, 32'hA2};
        mark();
        fix_lat = 1;
        do_start(32'h2000, 32'h1000, 16'd3, s0);
        wait_end(100, to, ec, we);
        settle(1);
        total++;
        if (to || we) begin
            bad++; $display("FAIL nom_end: timeout=%0d err=%0d want 0 0", to, we);
        end
        total++;
        if (ec - s0 != 13) begin
            bad++; $display("FAIL nom_latency: got %0d want 13", ec - s0);
        end
        total++;
        if (log_addr.size() - lb != 6) begin
            bad++; $display("FAIL nom_req_count: got %0d want 6", log_addr.size() - lb);
        end else begin
            for (int i = 0; i < 6; i++) begin
                total++;
                if (log_addr[lb+i] !== ea[i] || log_we[lb+i] != bit'(i % 2) ||
                    log_wd[lb+i] !== ew[i]) begin
                    bad++;
                    $display("FAIL nom_req%0d: got we=%0d a=%h d=%h want we=%0d a=%h d=%h",
                             i, log_we[lb+i], log_addr[lb+i], log_wd[lb+i],
                             i % 2, ea[i], ew[i]);
                end
            end
        end
        total++;
        if (words_done !== 16'd3) begin
            bad++; $display("FAIL nom_words_done: got %0d want 3", words_done);
        end
        total++;
        if (done_cnt - db != 1 || err_cnt - eb != 0 || be_bad - beb != 0) begin
            bad++;
            $display("FAIL nom_pulses: done=%0d err=%0d be_bad=%0d want 1 0 0",
                     done_cnt - db, err_cnt - eb, be_bad - beb);
        end
    endtask

    task automatic test_variable();
        bit to, we;
        int s0, ec;
        mark();
        lat_rand = 1'b1;
        do_start(32'h2000, 32'h1000, 16'd16, s0);
        wait_end(1000, to, ec, we);
        settle(1);
        lat_rand = 1'b0;
        total++;
        if (to || we) begin
            bad++; $display("FAIL var_end: timeout=%0d err=%0d want 0 0", to, we);
        end
        total++;
        if (log_addr.size() - lb != 32 || rd_hist.size() - rhb != 16) begin
            bad++;
            $display("FAIL var_counts: reqs=%0d reads=%0d want 32 16",
                     log_addr.size() - lb, rd_hist.size() - rhb);
        end else begin
            for (int i = 0; i < 16; i++) begin
                total++;
                if (log_addr[lb+2*i] !== 32'h2000 + 32'(4*i) ||
                    log_addr[lb+2*i+1] !== 32'h1000 + 32'(4*i) ||
                    log_wd[lb+2*i+1] !== rd_hist[rhb+i]) begin
                    bad++;
                    $display("FAIL var_word%0d: got ra=%h wa=%h wd=%h want wd=%h",
                             i, log_addr[lb+2*i], log_addr[lb+2*i+1],
                             log_wd[lb+2*i+1], rd_hist[rhb+i]);
                end
            end
        end
        total++;
        if (done_cnt - db != 1 || b2b - bb != 0) begin
            bad++;
            $display("FAIL var_pulses: done=%0d b2b=%0d want 1 0", done_cnt - db, b2b - bb);
        end
        total++;
        if (words_done !== 16'd16) begin
            bad++; $display("FAIL var_words_done: got %0d want 16", words_done);
        end
    endtask

    task automatic test_bus_error();
        bit to, we;
        int s0, ec;
        mark();
        fix_lat = 1;
        err_wr = 1;
        late_rv = 1'b1;
        do_start(32'h2000, 32'h1000, 16'd3, s0);
        wait_end(100, to, ec, we);
        settle(5);
        err_wr = -1;
        late_rv = 1'b0;
        total++;
        if (to || !we) begin
            bad++; $display("FAIL berr_end: timeout=%0d err=%0d want 0 1", to, we);
        end
        total++;
        if (err_code !== 2'd1 || err_addr !== 32'h1004) begin
            bad++;
            $display("FAIL berr_code: got %0d %h want 1 00001004", err_code, err_addr);
        end
        total++;
        if (words_done !== 16'd1) begin
            bad++; $display("FAIL berr_words_done: got %0d want 1", words_done);
        end
        total++;
        if (log_addr.size() - lb != 4) begin
            bad++; $display("FAIL berr_reqs: got %0d want 4", log_addr.size() - lb);
        end
        total++;
        if (err_cnt - eb != 1 || done_cnt - db != 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL berr_pulses: err=%0d done=%0d busy=%b want 1 0 0",
                     err_cnt - eb, done_cnt - db, busy);
        end
    endtask

    task automatic test_timeout();
        bit to, we;
        int s0, ec;
        mark();
        resp_en = 1'b0;
        do_start(32'h3000, 32'h1000, 16'd1, s0);
        wait_end(50, to, ec, we);
        settle(1);
        resp_en = 1'b1;
        total++;
        if (to || !we) begin
            bad++; $display("FAIL tmo_end: timeout=%0d err=%0d want 0 1", to, we);
        end
        total++;
        if (ec - s0 != 10) begin
            bad++; $display("FAIL tmo_latency: got %0d want 10", ec - s0);
        end
        total++;
        if (err_code !== 2'd2 || err_addr !== 32'h3000) begin
            bad++;
            $display("FAIL tmo_code: got %0d %h want 2 00003000", err_code, err_addr);
        end
        total++;
        if (log_addr.size() - lb != 1) begin
            bad++; $display("FAIL tmo_reqs: got %0d want 1", log_addr.size() - lb);
        end
    endtask

    task automatic test_misaligned();
        bit to, we;
        int s0, ec;
        mark();
        do_start(32'h2002, 32'h1000, 16'd4, s0);
        wait_end(20, to, ec, we);
        settle(1);
        total++;
        if (to || !we || ec - s0 != 1) begin
            bad++;
            $display("FAIL mis_src_end: timeout=%0d err=%0d lat=%0d want 0 1 1",
                     to, we, ec - s0);
        end
        total++;
        if (err_code !== 2'd3 || err_addr !== 32'h2002) begin
            bad++;
            $display("FAIL mis_src_code: got %0d %h want 3 00002002", err_code, err_addr);
        end
        do_start(32'h2000, 32'h1001, 16'd1, s0);
        wait_end(20, to, ec, we);
        settle(1);
        total++;
        if (err_code !== 2'd3 || err_addr !== 32'h1001) begin
            bad++;
            $display("FAIL mis_dst_code: got %0d %h want 3 00001001", err_code, err_addr);
        end
        total++;
        if (log_addr.size() - lb != 0) begin
            bad++; $display("FAIL mis_reqs: got %0d want 0", log_addr.size() - lb);
        end
    endtask

    task automatic test_len_zero();
        bit to, we;
        int s0, ec;
        mark();
        do_start(32'h2000, 32'h1000, 16'd0, s0);
        wait_end(20, to, ec, we);
        settle(1);
        total++;
        if (to || we || ec - s0 != 1) begin
            bad++;
            $display("FAIL len0_end: timeout=%0d err=%0d lat=%0d want 0 0 1",
                     to, we, ec - s0);
        end
        total++;
        if (log_addr.size() - lb != 0 || done_cnt - db != 1) begin
            bad++;
            $display("FAIL len0_reqs: reqs=%0d done=%0d want 0 1",
                     log_addr.size() - lb, done_cnt - db);
        end
    endtask

    task automatic test_wrap();
        bit to, we;
        int s0, ec;
        mark();
        fix_lat = 1;
        do_start(32'hFFFF_FFFC, 32'h1000, 16'd2, s0);
        wait_end(100, to, ec, we);
        settle(1);
        total++;
        if (to || we || words_done !== 16'd2) begin
            bad++;
            $display("FAIL wrap_end: timeout=%0d err=%0d words=%0d want 0 0 2",
                     to, we, words_done);
        end
        total++;
        if (log_addr.size() - lb != 4) begin
            bad++; $display("FAIL wrap_reqs: got %0d want 4", log_addr.size() - lb);
        end else begin
            total++;
            if (log_addr[lb] !== 32'hFFFF_FFFC || log_addr[lb+2] !== 32'h0) begin
                bad++;
                $display("FAIL wrap_addr: got %h %h want fffffffc 00000000",
                         log_addr[lb], log_addr[lb+2]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit to, we, found;
        int s0, ec;
        mark();
        fix_lat = 3;
        do_start(32'h2000, 32'h1000, 16'd3, s0);
        found = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (mem_req_o === 1'b1 && mem_we_o === 1'b1) begin
                found = 1;
                break;
            end
        end
        total++;
        if (!found) begin
            bad++; $display("FAIL rmid_wr_req: got none want write request");
        end
        @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL rmid_busy_pre: got %b want 1", busy);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({busy, done, error, mem_req_o, mem_we_o, mem_be_o} !== 9'b0 ||
            {mem_addr_o, mem_wdata_o, err_addr} !== 96'h0 ||
            err_code !== 2'd0 || words_done !== 16'd0) begin
            bad++;
            $display("FAIL rmid_outputs: got busy=%b req=%b addr=%h wd=%h wdone=%0d want 0",
                     busy, mem_req_o, mem_addr_o, mem_wdata_o, words_done);
        end
        settle(6);
        total++;
        if (log_addr.size() - lb != 2 || busy !== 1'b0 || words_done !== 16'd0) begin
            bad++;
            $display("FAIL rmid_quiet: reqs=%0d busy=%b words=%0d want 2 0 0",
                     log_addr.size() - lb, busy, words_done);
        end
        mark();
        fix_lat = 1;
        do_start(32'h2000, 32'h1000, 16'd2, s0);
        wait_end(100, to, ec, we);
        settle(1);
        total++;
        if (to || we || words_done !== 16'd2 || log_addr.size() - lb != 4) begin
            bad++;
            $display("FAIL rmid_restart: timeout=%0d err=%0d words=%0d reqs=%0d want 0 0 2 4",
                     to, we, words_done, log_addr.size() - lb);
        end
    endtask

    task automatic test_start_busy();
        bit to, we;
        int s0, ec;
        mark();
        fix_lat = 2;
        do_start(32'h2000, 32'h1000, 16'd2, s0);
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL sbusy_busy: got %b want 1", busy);
        end
        start = 1'b1;
        src_addr = 32'h2100;
        dst_addr = 32'h1100;
        len_words = 16'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_end(100, to, ec, we);
        settle(4);
        total++;
        if (to || we || words_done !== 16'd2 || done_cnt - db != 1) begin
            bad++;
            $display("FAIL sbusy_end: timeout=%0d err=%0d words=%0d done=%0d want 0 0 2 1",
                     to, we, words_done, done_cnt - db);
        end
        total++;
        if (log_addr.size() - lb != 4) begin
            bad++; $display("FAIL sbusy_reqs: got %0d want 4", log_addr.size() - lb);
        end else begin
            total++;
            if (log_addr[lb+2] !== 32'h2004 || log_addr[lb+3] !== 32'h1004) begin
                bad++;
                $display("FAIL sbusy_addr: got %h %h want 00002004 00001004",
                         log_addr[lb+2], log_addr[lb+3]);
            end
        end
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL sbusy_idle: got %b want 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_variable();
        test_bus_error();
        test_timeout();
        test_misaligned();
        test_len_zero();
        test_wrap();
        test_reset_mid();
        test_start_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
